// File: rtl/round_decryptor.sv
// Iterative 8-bit, 10-round block decryptor: applies round keys k10..k1, one per clock, then strips k0.
// Optional ROUND_DEC_ENC_MODE_EN adds a mode port selecting the forward (encrypt) datapath.
module round_decryptor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dout
`ifdef ROUND_DEC_ENC_MODE_EN
  ,
  input  logic       mode
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] s_q, s_d;
  logic [3:0] round_q, round_d;
  logic [7:0] dout_q, dout_d;
  logic       enc_q;

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] rotr1(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  // Round key schedule, derived on the fly from the latched master key.
  function automatic logic [7:0] rkey(input logic [7:0] k, input logic [3:0] r);
    case (r)
      4'd1:    rkey = rotl1(k);
      4'd2:    rkey = k ^ 8'hAA;
      4'd3:    rkey = rotr1(k);
      4'd4:    rkey = ~k;
      4'd5:    rkey = k + 8'h1F;
      4'd6:    rkey = k - 8'h1F;
      4'd7:    rkey = {k[3:0], k[7:4]};
      4'd8:    rkey = k ^ 8'h55;
      4'd9:    rkey = {k[5:0], k[7:6]};
      4'd10:   rkey = rotl1(k);
      default: rkey = k;
    endcase
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 8'h00;
      s_q     <= 8'h00;
      round_q <= 4'd0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      s_q     <= s_d;
      round_q <= round_d;
      dout_q  <= dout_d;
    end
  end

`ifdef ROUND_DEC_ENC_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         enc_q <= 1'b0;
    else if (state_q == IDLE && in_valid) enc_q <= mode;
  end
`else
  assign enc_q = 1'b0;
`endif

  always_comb begin
    logic [3:0] idx;
    logic [7:0] rk;
    logic [7:0] step;
    state_d = state_q;
    key_d   = key_q;
    s_d     = s_q;
    round_d = round_q;
    dout_d  = dout_q;
    idx     = 4'd0;
    rk      = 8'h00;
    step    = 8'h00;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = in_key;
          s_d     = din;
`ifdef ROUND_DEC_ENC_MODE_EN
          if (mode) s_d = din ^ in_key;
`endif
          round_d = 4'd10;
          state_d = RUN;
        end
      end
      RUN: begin
        if (round_q == 4'd0 || round_q > 4'd10) begin
          state_d = IDLE;
          round_d = 4'd0;
        end else begin
          // Encrypt walks keys upward while the counter still counts down.
          idx     = enc_q ? (4'd11 - round_q) : round_q;
          rk      = rkey(key_q, idx);
          step    = enc_q ? (rotl1(s_q) + rk) : rotr1(s_q - rk);
          s_d     = step;
          round_d = round_q - 4'd1;
          if (round_q == 4'd1) begin
            dout_d  = enc_q ? step : (step ^ key_q);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/round_decryptor.md
# round_decryptor

Iterative 8-bit, 10-round block decryptor: inverse of the team's round encryption datapath. It accepts one ciphertext byte plus an 8-bit master key over a valid/ready handshake. It derives the round keys internally and applies them in reverse order, k10 down to k1, one round per clock, then strips the k0 whitening. It returns the plaintext over a second valid/ready handshake and sits between the receive path and the plaintext consumer.

## Interface
- No parameters; data and key width fixed at 8 bits, round count fixed at 10.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- in_valid  input  1  ciphertext/key present.
- in_ready  output  1  block can accept; high only in IDLE.
- din  input  8  ciphertext byte.
- in_key  input  8  master key; sampled with din.
- out_valid  output  1  dout holds a result.
- out_ready  input  1  consumer accepts dout.
- dout  output  8  plaintext byte (registered).
- mode  input  1  only with ROUND_DEC_ENC_MODE_EN: 1 = encrypt, 0 = decrypt.

## Operation
- Round keys from latched key K, all mod 256:
  - k0 = K; k1 = rotl1(K); k2 = K^8'hAA; k3 = rotr1(K).
  - k4 = ~K; k5 = K+8'h1F; k6 = K-8'h1F; k7 = {K[3:0],K[7:4]}.
  - k8 = K^8'h55; k9 = rotl2(K); k10 = rotl1(K).
- Encryption, for reference: s = P^k0, then for r = 1..10: s = rotl1(s) + k_r.
- Decryption: for r = 10 down to 1: s = rotr1(s - k_r); P = s ^ k0.
- Arithmetic is 8-bit wrap-around; carry and borrow are discarded.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: latch K, s=din, round=10; go to RUN.
  - RUN: each cycle s = rotr1(s - k_round), round decrements. When round==1, the update also XORs k0, sets out_valid, loads dout, and goes to DONE.
  - DONE: dout and out_valid held stable until out_ready; on out_valid&out_ready go to IDLE.
- Key registers are not reloaded mid-operation; changes on din, in_key and in_valid outside IDLE are ignored.
- Round counter is 4 bits; values 0 and 11-15 are unreachable. If reached, FSM returns to IDLE.

## Timing
- Reset (asynchronous, any state, including mid-RUN or DONE):
  - FSM=IDLE; in_ready=1; out_valid=0; dout=8'h00.
  - State, key and round registers cleared.
  - No partial result is ever presented.
- Acceptance edge E0 (in_valid & in_ready). in_ready drops in the cycle after E0.
- Round edges E1..E10 apply k10..k1. out_valid=1 and dout is valid after E10: latency 10 cycles from acceptance.
- If out_ready is already high when out_valid rises, the handshake completes at E11. in_ready=1 after E11; the next acceptance is possible at E12. Peak throughput is one byte per 12 cycles.
- Backpressure: out_valid/dout hold indefinitely while out_ready=0.
- in_ready is combinational from FSM state only; it has no dependency on out_ready.

## Configuration
- ROUND_DEC_ENC_MODE_EN defined:
  - Adds the mode input port, sampled at acceptance.
  - mode=1: s = din^k0 at acceptance. Rounds E1..E10 compute s = rotl1(s) + k_r with r ascending 1..10; the result appears after E10.
  - mode=0: decrypt as above.
  - Latency and handshake are identical in both modes.
- ROUND_DEC_ENC_MODE_EN undefined: no mode port; decrypt only.

## Test plan
- Reset: assert rst_n=0 mid-RUN -> immediately in_ready=1, out_valid=0, dout=8'h00. After release, the next transfer decrypts correctly.
- Known answer: in_key=8'h00, din=8'hB1, out_ready=1 -> out_valid high exactly 10 cycles after acceptance with dout=8'h00. in_ready low throughout RUN.
- Backpressure: same vector, out_ready=0 for 6 cycles after out_valid -> dout=8'h00 stable and in_ready=0 for those cycles. Raising out_ready completes the handshake; in_ready=1 next cycle.
- Busy ignore: during RUN, drive in_valid=1, din=8'h5A, in_key=8'hFF -> result unchanged (8'h00). The new data is not captured until in_ready=1.
- Wrap-around: all 256 keys × 256 plaintexts, each encrypted by the bench model and then decrypted -> dout equals the original plaintext every time.
- With ROUND_DEC_ENC_MODE_EN: mode=1, in_key=8'h00, din=8'h00 -> dout=8'hB1 after 10 cycles. Feeding the result back with mode=0 -> 8'h00.
